// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width and the serial-op control states.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : alu_pkg

// File: rtl/full_subtractor_1b.sv
// 1-bit full subtractor (a - b - bin); borrow-chain twin of the ALU adder cell.
module full_subtractor_1b (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule : full_subtractor_1b

// File: rtl/serial_subtractor_8b.sv
// Bit-serial subtractor: result = operand_a - operand_b, LSB first, one bit per clock.
// WIDTH must be at least 2.
module serial_subtractor_8b
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             borrow,
  output logic             zero,
  output logic             overflow
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  state_t             state;
  logic [WIDTH-1:0]   a_sr;
  logic [WIDTH-1:0]   b_sr;
  logic [WIDTH-1:0]   diff_sr;
  logic               a_msb;
  logic               b_msb;
  logic               bin_q;
  logic [CNT_W-1:0]   count;

  logic               d_c;
  logic               bout_c;
  logic               last_bit_c;
  logic [WIDTH-1:0]   diff_next_c;

  full_subtractor_1b u_fs (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (bin_q),
    .d    (d_c),
    .bout (bout_c)
  );

  // Difference bits arrive LSB first, so they enter at the MSB and shift down.
  assign diff_next_c = {d_c, diff_sr[WIDTH-1:1]};
  assign last_bit_c  = (count == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      diff_sr  <= '0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      bin_q    <= 1'b0;
      count    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      borrow   <= 1'b0;
      zero     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= operand_a;
            b_sr  <= operand_b;
            a_msb <= operand_a[WIDTH-1];
            b_msb <= operand_b[WIDTH-1];
            bin_q <= 1'b0;
            count <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end

        RUN: begin
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          diff_sr <= diff_next_c;
          bin_q   <= bout_c;
          count   <= count + CNT_W'(1);
          if (last_bit_c) begin
            // Final bit: d_c is the result sign, bout_c the unsigned borrow.
            result   <= diff_next_c;
            borrow   <= bout_c;
            zero     <= (diff_next_c == '0);
            overflow <= (a_msb != b_msb) && (d_c != a_msb);
            done     <= 1'b1;
            state    <= DONE;
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule : serial_subtractor_8b

// File: tb/tb_serial_subtractor_8b.sv
// Self-checking bench for serial_subtractor_8b against an arithmetic reference model.
module tb_serial_subtractor_8b;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] operand_a;
  logic [W-1:0] operand_b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         borrow;
  logic         zero;
  logic         overflow;

  int n_checks;
  int n_errors;

  // Values the outputs are expected to hold (last completed operation).
  logic [W-1:0] exp_res;
  logic         exp_brw;
  logic         exp_zero;
  logic         exp_ovf;

  serial_subtractor_8b #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .borrow    (borrow),
    .zero      (zero),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer subtraction, unsigned compare, signed range test.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b);
    int sa;
    int sb;
    int sd;
    sa = int'($signed(a));
    sb = int'($signed(b));
    sd = sa - sb;
    exp_res  = W'(int'(a) - int'(b));
    exp_brw  = (a < b);
    exp_zero = (a == b);
    exp_ovf  = (sd > 127) || (sd < -128);
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, ".result"},   32'(result),   32'(exp_res));
    chk({tag, ".borrow"},   32'(borrow),   32'(exp_brw));
    chk({tag, ".zero"},     32'(zero),     32'(exp_zero));
    chk({tag, ".overflow"}, 32'(overflow), 32'(exp_ovf));
  endtask

  // One operation; glitch_cyc > 0 pulses start with junk operands on that RUN cycle.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int glitch_cyc);
    @(negedge clk);
    operand_a = a;
    operand_b = b;
    start     = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, ".accept_busy"}, 32'(busy), 32'd1);
    chk({tag, ".accept_done"}, 32'(done), 32'd0);
    for (int k = 1; k <= int'(W); k++) begin
      @(negedge clk);
      start     = (k == glitch_cyc);
      operand_a = W'($urandom);
      operand_b = W'($urandom);
      @(posedge clk);
      #1;
      if (k < int'(W)) begin
        chk({tag, ".run_done"}, 32'(done), 32'd0);
        chk({tag, ".run_busy"}, 32'(busy), 32'd1);
        chk({tag, ".run_hold"}, 32'(result), 32'(exp_res));
      end
    end
    model(a, b);
    chk({tag, ".done"}, 32'(done), 32'd1);
    chk({tag, ".done_busy"}, 32'(busy), 32'd1);
    chk_outputs(tag);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, ".done_fall"}, 32'(done), 32'd0);
    chk({tag, ".idle_busy"}, 32'(busy), 32'd0);
    chk_outputs({tag, ".hold"});
  endtask

  initial begin
    logic [W-1:0] a1, b1, a2, b2;
    int done_cnt;

    n_checks  = 0;
    n_errors  = 0;
    exp_res   = '0;
    exp_brw   = 1'b0;
    exp_zero  = 1'b0;
    exp_ovf   = 1'b0;
    rst_n     = 1'b0;
    start     = 1'b0;
    operand_a = '0;
    operand_b = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.done", 32'(done), 32'd0);
    chk_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Idle with start low: nothing happens.
    repeat (3) @(posedge clk);
    #1;
    chk("idle.busy", 32'(busy), 32'd0);

    run_op("t05_03", 8'h05, 8'h03, 0);
    run_op("t03_05", 8'h03, 8'h05, 0);
    run_op("t80_01", 8'h80, 8'h01, 0);
    run_op("t7f_ff", 8'h7F, 8'hFF, 0);
    run_op("t55_55", 8'h55, 8'h55, 0);
    run_op("t00_00", 8'h00, 8'h00, 0);
    run_op("glitch", 8'hC3, 8'h29, 3);

    // Start held high across two operations.
    a1 = 8'h9A; b1 = 8'h3C; a2 = 8'h11; b2 = 8'h77;
    @(negedge clk);
    operand_a = a1;
    operand_b = b1;
    start     = 1'b1;
    @(posedge clk);
    done_cnt = 0;
    for (int e = 1; e <= 19; e++) begin
      @(negedge clk);
      operand_a = a2;
      operand_b = b2;
      if (e == 11) start = 1'b0;
      @(posedge clk);
      #1;
      if (done === 1'b1) done_cnt++;
      chk($sformatf("b2b.done_e%0d", e), 32'(done), 32'((e == 8) || (e == 18)));
      chk($sformatf("b2b.busy_e%0d", e), 32'(busy), 32'(!((e == 9) || (e == 19))));
      if (e == 8) begin
        model(a1, b1);
        chk_outputs("b2b.op1");
      end
      if (e == 18) begin
        model(a2, b2);
        chk_outputs("b2b.op2");
      end
    end
    chk("b2b.done_count", 32'(done_cnt), 32'd2);

    // Asynchronous reset during RUN cycle 4.
    @(negedge clk);
    operand_a = 8'hE7;
    operand_b = 8'h18;
    start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp_res  = '0;
    exp_brw  = 1'b0;
    exp_zero = 1'b0;
    exp_ovf  = 1'b0;
    chk("arst.busy", 32'(busy), 32'd0);
    chk("arst.done", 32'(done), 32'd0);
    chk_outputs("arst");
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int e = 0; e < 12; e++) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0 || busy !== 1'b0) done_cnt++;
    end
    chk("arst.no_done", 32'(done_cnt), 32'd0);
    run_op("t10_01", 8'h10, 8'h01, 0);

    // Random operations, some with an ignored mid-run start pulse.
    for (int i = 0; i < 24; i++) begin
      run_op($sformatf("rnd%0d", i), W'($urandom), W'($urandom),
             int'($urandom_range(0, W - 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_serial_subtractor_8b
